demux_scan_ctrl: RTL and testbench
==================================

Name: demux_scan_ctrl

Overview:
- Upstream driver for the team's 1-to-4 demultiplexer (inputs `w`, `sel[1:0]`). Feeds those two inputs directly.
- Snapshots a 4-bit data word and a 4-bit channel mask, then steps `sel` through the enabled channels in ascending order. Each channel's bit is held on `w` for a programmable dwell time.
- Supports single-pass and continuous scanning. Used for LED/relay multiplexing on the lab FPGA board.

Parameters:
- CLK_DIV, 50000: clock cycles per channel slot (dwell); legal range 1..2^DIV_W-1.
- DIV_W, 16: width of the dwell counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  start/continue scanning; level-sensitive.
- cont  input  1  1 = continuous scanning (reload after each frame); 0 = single pass.
- mask  input  4  channel enable; bit i enables channel i.
- data_in  input  4  per-channel data; bit i is sent on `w` while `sel` = i.
- w  output  1  serial data to the demux; registered.
- sel  output  2  channel select to the demux; registered.
- busy  output  1  high in any state other than IDLE; registered.
- frame_done  output  1  one-cycle pulse after the last enabled channel's slot; registered.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: w=0, sel=0, busy=0, frame_done=0, state=IDLE, dwell counter=0, shadow registers=0.
- Reset wins over every other input. Asserting `rst` mid-slot returns to IDLE on the next edge, with no frame_done pulse.

States:
- IDLE: w=0, sel holds its last value, busy=0.
  - If en=1 and mask!=0, go to LOAD.
  - If en=1 and mask==0, stay in IDLE. No pulse.
- LOAD (1 cycle): data_in→dshadow, mask→mshadow. sel ← lowest set bit of mask. Counter ← 0. Go to DWELL.
- DWELL: w = dshadow[sel]. Counter increments each cycle.
  - When counter == CLK_DIV-1, go to NEXT.
- NEXT (1 cycle):
  - If a higher-indexed channel is set in mshadow: sel ← the lowest such channel, counter ← 0, go back to DWELL. w takes the new channel's bit in the same cycle (make-before-break).
  - Otherwise the frame is complete: frame_done=1 for this cycle and w=0.
    - If en=1 and cont=1, go to LOAD.
    - Else go to IDLE.

Timing:
- Latency: en sampled high in IDLE at edge k. `sel`/`w` are valid from edge k+2.
- Channel i occupies CLK_DIV cycles. The NEXT cycle adds 1 cycle per step.
- Full frame with n enabled channels: 1 (LOAD) + n·CLK_DIV + n (NEXT cycles) cycles.

Boundary and mid-operation rules:
- data_in and mask changes during a frame are ignored; the shadow copies are used. New values take effect at the next LOAD.
- en drop mid-frame: the current frame completes, frame_done pulses, then the block returns to IDLE.
- cont changes are sampled only in NEXT.
- Only channel 3 enabled: one slot per frame, sel=3 throughout.
- Continuous mode with mask becoming 0: the LOAD after that frame sees mask==0, returns to IDLE with w=0, and does not pulse.
- CLK_DIV=1: each slot is 1 DWELL cycle plus 1 NEXT cycle.

Optional Feature:
- Macro: SCAN_GAP_EN.
- Defined: break-before-make.
  - In NEXT, w is forced to 0 for one cycle while sel advances.
  - DWELL then drives the new channel's bit.
  - Slot timing is otherwise identical.
- Undefined: w switches to the new channel's bit in the same cycle that sel advances, as described under Behaviour.

Test Plan (CLK_DIV=4):
- Reset value check: assert rst for 2 cycles → w=0, sel=0, busy=0, frame_done=0.
- Single pass, full mask: mask=4'b1111, data_in=4'b1010, cont=0, pulse en for 1 cycle.
  - sel=0,1,2,3 each for 4 DWELL cycles, with w=0,1,0,1.
  - frame_done pulses once, 21 cycles after LOAD, then IDLE with busy=0.
- Sparse mask: mask=4'b1001, data_in=4'b1111 → sel visits only 0 then 3, w=1, frame_done after 2 slots.
- mask=0: en=1 held, mask=0 → busy stays 0, w=0, no frame_done.
- Continuous mode with shadowing: cont=1, en=1, mask=4'b0011.
  - Change data_in from 4'b0001 to 4'b0010 mid-frame → current frame still outputs w=1,0.
  - The next frame, after LOAD, outputs w=0,1.
  - Drop en → the current frame finishes, then IDLE.
- Reset mid-slot: rst asserted during DWELL on sel=2 → next edge: w=0, busy=0, sel=0, no frame_done.
- Both SCAN_GAP_EN builds: run the single-pass full-mask case with the macro defined and undefined.
  - Defined: w=0 for exactly one cycle at each sel change.
  - Undefined: no gap cycle.

Source files
------------

// File: rtl/demux_scan_ctrl.sv
// demux_scan_ctrl: steps a 1-to-4 demux select through the enabled channels, holding each channel's data bit on w
// Ports: clk, rst (sync, active-high); en/cont start and repeat scans; mask/data_in are snapshotted at LOAD;
//        w/sel drive the demux; busy is high outside IDLE; frame_done pulses after the last slot of a frame.
// Build option: define SCAN_GAP_EN for break-before-make (w held low for one cycle whenever sel advances).
module demux_scan_ctrl #(
    parameter int CLK_DIV = 50000,
    parameter int DIV_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       cont,
    input  logic [3:0] mask,
    input  logic [3:0] data_in,
    output logic       w,
    output logic [1:0] sel,
    output logic       busy,
    output logic       frame_done
);
    typedef enum logic [1:0] {IDLE, LOAD, DWELL, NEXT} state_t;
`ifdef SCAN_GAP_EN
    localparam logic GAP = 1'b1;
`else
    localparam logic GAP = 1'b0;
`endif
    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q;
    logic [3:0]       dsh_q, msh_q, hi;
    logic [1:0]       sel_q;
    logic             w_q, busy_q, done_q;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
    endfunction

    // enabled channels strictly above the one currently selected
    assign hi = msh_q & (4'b1110 << sel_q);

    always_comb begin
        state_d = state_q == IDLE  ? ((en && mask != 4'd0) ? LOAD : IDLE) :
                  state_q == LOAD  ? ((mask != 4'd0) ? DWELL : IDLE) :
                  state_q == DWELL ? ((cnt_q == DIV_W'(CLK_DIV - 1)) ? NEXT : DWELL) :
                  (|hi) ? DWELL : ((en && cont) ? LOAD : IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dsh_q   <= '0;
            msh_q   <= '0;
            sel_q   <= '0;
            w_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= state_d != IDLE;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: w_q <= 1'b0;
                LOAD: begin
                    dsh_q <= data_in;
                    msh_q <= mask;
                    cnt_q <= '0;
                    // a mask cleared since IDLE aborts quietly, keeping sel where it was
                    if (mask != 4'd0) begin
                        sel_q <= lowest(mask);
                        w_q   <= data_in[lowest(mask)];
                    end else begin
                        w_q <= 1'b0;
                    end
                end
                DWELL: begin
                    cnt_q <= cnt_q + 1'b1;
                    w_q   <= dsh_q[sel_q];
                end
                NEXT: begin
                    if (|hi) begin
                        sel_q <= lowest(hi);
                        cnt_q <= '0;
                        w_q   <= GAP ? 1'b0 : dsh_q[lowest(hi)];
                    end else begin
                        done_q <= 1'b1;
                        w_q    <= 1'b0;
                    end
                end
                default: w_q <= 1'b0;
            endcase
        end
    end

    assign w          = w_q;
    assign sel        = sel_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_demux_scan_ctrl.sv
// tb_demux_scan_ctrl: directed tables, corner sequences and random traffic checked against a frame-queue model
module tb_demux_scan_ctrl;
    localparam int D = 4;
`ifdef SCAN_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif
    logic clk = 1'b0, rst, en, cont, w, busy, frame_done;
    logic [3:0] mask, data_in;
    logic [1:0] sel;
    int checks = 0, failures = 0;

    demux_scan_ctrl #(.CLK_DIV(D), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .cont(cont), .mask(mask), .data_in(data_in),
        .w(w), .sel(sel), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic w; logic [1:0] sel;} ent_t;
    ent_t fq[$];
    int ph = 0;
    logic m_w = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    logic [1:0] m_sel = 2'd0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pop_ent();
        ent_t e;
        e = fq.pop_front();
        m_w = e.w;
        m_sel = e.sel;
    endtask

    // Frame-level reference: at LOAD a frame becomes a queue of per-cycle (sel, w) slots,
    // each enabled channel owning D+1 cycles; an empty queue marks the frame-end cycle.
    task automatic model_step();
        bit first;
        ent_t e;
        if (rst) begin
            ph = 0; fq.delete(); m_w = 0; m_sel = 0; m_busy = 0; m_done = 0;
        end else if (ph == 0) begin
            m_w = 0; m_done = 0;
            ph = (en && mask != 0) ? 1 : 0;
            m_busy = (ph == 1);
        end else if (ph == 1) begin
            m_done = 0;
            if (mask == 0) begin
                ph = 0; m_w = 0; m_busy = 0;
            end else begin
                first = 1;
                for (int c = 0; c < 4; c++) begin
                    if (mask[c]) begin
                        for (int k = 0; k <= D; k++) begin
                            e.sel = 2'(c);
                            e.w = (k == 0 && !first && GAP) ? 1'b0 : data_in[c];
                            fq.push_back(e);
                        end
                        first = 0;
                    end
                end
                pop_ent();
                ph = 2; m_busy = 1;
            end
        end else if (fq.size() > 0) begin
            pop_ent(); m_done = 0; m_busy = 1;
        end else begin
            m_done = 1; m_w = 0; m_busy = en && cont; ph = m_busy ? 1 : 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("w", w, m_w);
        chk("sel", sel, m_sel);
        chk("busy", busy, m_busy);
        chk("frame_done", frame_done, m_done);
    endtask

    typedef struct {
        logic [3:0] mask;
        logic [3:0] data;
        int n;
        logic [1:0] s[4];
        logic [3:0] wv;
        int busy_n;
        int done_n;
    } vec_t;
    vec_t tv[5];

    initial begin
        int busy_n, done_n;
        tv[0] = '{4'b1111, 4'b1010, 4, '{2'd0, 2'd1, 2'd2, 2'd3}, 4'b1010, 21, 1};
        tv[1] = '{4'b1001, 4'b1111, 2, '{2'd0, 2'd3, 2'd0, 2'd0}, 4'b0011, 11, 1};
        tv[2] = '{4'b1000, 4'b1000, 1, '{2'd3, 2'd0, 2'd0, 2'd0}, 4'b0001, 6, 1};
        tv[3] = '{4'b0110, 4'b0100, 2, '{2'd1, 2'd2, 2'd0, 2'd0}, 4'b0010, 11, 1};
        tv[4] = '{4'b0000, 4'b1111, 0, '{2'd0, 2'd0, 2'd0, 2'd0}, 4'b0000, 0, 0};
        rst = 1; en = 0; cont = 0; mask = 0; data_in = 0;
        cyc(); cyc();
        chk("rst_w", w, 0); chk("rst_sel", sel, 0); chk("rst_busy", busy, 0); chk("rst_done", frame_done, 0);
        rst = 0;
        cyc();
        for (int v = 0; v < 5; v++) begin
            mask = tv[v].mask; data_in = tv[v].data; cont = 0; en = 1;
            busy_n = 0; done_n = 0;
            for (int t = 1; t <= 30; t++) begin
                cyc();
                if (t == 1) en = 0;
                busy_n += int'(busy);
                done_n += int'(frame_done);
                for (int j = 0; j < tv[v].n; j++) begin
                    if (t == 3 + 5 * j) begin
                        chk("tab_sel", sel, tv[v].s[j]);
                        chk("tab_w", w, tv[v].wv[j]);
                    end
                    if (j > 0 && t == 2 + 5 * j) chk("tab_gap_w", w, GAP ? 0 : int'(tv[v].wv[j]));
                end
                if (tv[v].n > 0 && t == 2 + 5 * tv[v].n) chk("tab_done_at", frame_done, 1);
            end
            chk("tab_busy_cycles", busy_n, tv[v].busy_n);
            chk("tab_done_count", done_n, tv[v].done_n);
        end
        // continuous scan with data change mid-frame, then en drop
        cont = 1; en = 1; mask = 4'b0011; data_in = 4'b0001;
        for (int t = 1; t <= 26; t++) begin
            cyc();
            if (t == 3) begin chk("cont_f1s0_w", w, 1); chk("cont_f1s0_sel", sel, 0); end
            if (t == 4) data_in = 4'b0010;
            if (t == 8) begin chk("cont_f1s1_w", w, 0); chk("cont_f1s1_sel", sel, 1); end
            if (t == 12) begin chk("cont_f1_done", frame_done, 1); chk("cont_f1_busy", busy, 1); end
            if (t == 14) begin chk("cont_f2s0_w", w, 0); chk("cont_f2s0_sel", sel, 0); end
            if (t == 15) en = 0;
            if (t == 19) begin chk("cont_f2s1_w", w, 1); chk("cont_f2s1_sel", sel, 1); end
            if (t == 23) begin chk("cont_f2_done", frame_done, 1); chk("cont_f2_busy", busy, 0); end
            if (t == 24) chk("cont_idle_busy", busy, 0);
        end
        // continuous scan whose mask goes to zero: the reload aborts without a pulse
        cont = 1; en = 1; mask = 4'b0001; data_in = 4'b0001;
        for (int t = 1; t <= 12; t++) begin
            cyc();
            if (t == 3) chk("mz_w", w, 1);
            if (t == 4) mask = 4'b0000;
            if (t == 7) begin chk("mz_done", frame_done, 1); chk("mz_busy_load", busy, 1); end
            if (t == 8) begin chk("mz_abort_busy", busy, 0); chk("mz_abort_done", frame_done, 0); chk("mz_abort_w", w, 0); end
            if (t == 12) begin chk("mz_idle_busy", busy, 0); chk("mz_idle_w", w, 0); end
        end
        // reset during a slot on channel 2
        en = 1; cont = 0; mask = 4'b0100; data_in = 4'b0100;
        done_n = 0;
        for (int t = 1; t <= 20; t++) begin
            cyc();
            if (t == 1) en = 0;
            if (t == 4) begin chk("rmid_sel", sel, 2); chk("rmid_w", w, 1); rst = 1; end
            if (t == 5) begin
                chk("rmid_w0", w, 0); chk("rmid_busy0", busy, 0); chk("rmid_sel0", sel, 0); chk("rmid_done0", frame_done, 0);
                rst = 0;
            end
            if (t > 4) done_n += int'(frame_done);
        end
        chk("rmid_no_done", done_n, 0);
        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom % 4) != 0;
            cont = $urandom % 2;
            if ($urandom % 8 == 0) mask = 4'($urandom);
            data_in = 4'($urandom);
            rst = ($urandom % 150) == 0;
            cyc();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
